// File: rtl/fetch_pkg.sv
// Shared fetch-path types and sizes used by fetch, fetch_queue and decode.
package fetch_pkg;
  localparam int INSTR_W  = 9;
  localparam int FQ_DEPTH = 4;

  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle; master is the fetch/decode side, slave is the queue.
interface fetch_queue_if #(
  parameter int WIDTH = fetch_pkg::INSTR_W,
  parameter int CNT_W = $clog2(fetch_pkg::FQ_DEPTH) + 1
);
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, count
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, count
  );
endinterface

// File: rtl/fetch_queue_mem.sv
// Queue storage: DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Contents are not reset; validity is tracked by the occupancy count in the parent.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode; 1-cycle push-to-head latency, in_ready = !full
// (state-only, no path from out_ready); flush empties in one cycle. Optional FETCH_QUEUE_STATS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = FQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]   stall_cycles
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Flush wins: the incoming instruction is wrong-path and the head is not consumed.
  assign push = q.in_valid && !full && !q.flush;
  assign pop  = q.out_ready && !empty && !q.flush;

  assign q.in_ready  = !full;
  assign q.out_valid = !empty;
  assign q.out_instr = empty ? '0 : rdata;
  assign q.count     = count_q;

  fetch_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (q.in_instr),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_q;

  // Counts cycles fetch is held off by a full queue; survives flush, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (q.in_valid && full && !q.flush && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty));
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: model queue filled on accepted pushes, compared on pops.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  instr_t sb[$];

  fetch_queue_if #(.WIDTH(9), .CNT_W(3)) fq();

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cycles;
  fetch_queue dut (.clk(clk), .reset(reset), .q(fq), .stall_cycles(stall_cycles));
`else
  fetch_queue dut (.clk(clk), .reset(reset), .q(fq));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus from a negedge to the next; updates the scoreboard.
  task automatic step(input logic iv, input instr_t d, input logic orr, input logic fl,
                      output logic popped, output instr_t act, output instr_t exp_v);
    logic   can_push;
    instr_t tmp;
    fq.in_valid  = iv;
    fq.in_instr  = d;
    fq.out_ready = orr;
    fq.flush     = fl;
    #1;
    can_push = (sb.size() < 4);
    popped   = orr && !fl && (sb.size() > 0);
    act      = fq.out_instr;
    exp_v    = popped ? sb[0] : '0;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (popped) tmp = sb.pop_front();
      if (iv && can_push) sb.push_back(d);
    end
    @(negedge clk);
    fq.in_valid  = 1'b0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic p; instr_t a, e;
    total_cnt++; if (fq.count !== 3'd0) $display("FAIL rst_count act=%0d exp=0", fq.count); else pass_cnt++;
    total_cnt++; if (fq.out_valid !== 1'b0) $display("FAIL rst_out_valid act=%b exp=0", fq.out_valid); else pass_cnt++;
    total_cnt++; if (fq.in_ready !== 1'b1) $display("FAIL rst_in_ready act=%b exp=1", fq.in_ready); else pass_cnt++;
    total_cnt++; if (fq.out_instr !== 9'h000) $display("FAIL rst_out_instr act=%h exp=000", fq.out_instr); else pass_cnt++;
    for (int i = 0; i < 3; i++) step(1'b1, instr_t'(9'h0A0 + i), 1'b0, 1'b0, p, a, e);
    total_cnt++; if (fq.count !== 3'd3) $display("FAIL pre_rst_count act=%0d exp=3", fq.count); else pass_cnt++;
    // Async reset asserted mid-cycle; outputs must clear before the next edge.
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    total_cnt++; if (fq.count !== 3'd0) $display("FAIL async_rst_count act=%0d exp=0", fq.count); else pass_cnt++;
    total_cnt++; if (fq.out_valid !== 1'b0) $display("FAIL async_rst_out_valid act=%b exp=0", fq.out_valid); else pass_cnt++;
    total_cnt++; if (fq.in_ready !== 1'b1) $display("FAIL async_rst_in_ready act=%b exp=1", fq.in_ready); else pass_cnt++;
    #27;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic p; instr_t a, e;
    for (int i = 1; i <= 4; i++) step(1'b1, instr_t'(i), 1'b0, 1'b0, p, a, e);
    total_cnt++; if (fq.count !== 3'd4) $display("FAIL full_count act=%0d exp=4", fq.count); else pass_cnt++;
    total_cnt++; if (fq.in_ready !== 1'b0) $display("FAIL full_in_ready act=%b exp=0", fq.in_ready); else pass_cnt++;
    step(1'b1, 9'h005, 1'b0, 1'b0, p, a, e);
    total_cnt++; if (fq.count !== 3'd4) $display("FAIL refused_count act=%0d exp=4", fq.count); else pass_cnt++;
    total_cnt++; if (fq.out_instr !== 9'h001) $display("FAIL refused_head act=%h exp=001", fq.out_instr); else pass_cnt++;
  endtask

  task automatic test_drain_wrap();
    logic p; instr_t a, e;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, p, a, e);
      total_cnt++; if (!p || a !== e) $display("FAIL drain_%0d act=%h exp=%h popped=%b", i, a, e, p); else pass_cnt++;
    end
    total_cnt++; if (fq.out_valid !== 1'b0) $display("FAIL drained_out_valid act=%b exp=0", fq.out_valid); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, instr_t'(9'h040 + i * 3), 1'b0, 1'b0, p, a, e);
      step(1'b0, '0, 1'b1, 1'b0, p, a, e);
      total_cnt++; if (!p || a !== e) $display("FAIL wrap_%0d act=%h exp=%h popped=%b", i, a, e, p); else pass_cnt++;
    end
    total_cnt++; if (fq.count !== 3'd0) $display("FAIL wrap_count act=%0d exp=0", fq.count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic p; instr_t a, e;
    step(1'b1, 9'h020, 1'b0, 1'b0, p, a, e);
    step(1'b1, 9'h021, 1'b0, 1'b0, p, a, e);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, instr_t'(9'h010 + i), 1'b1, 1'b0, p, a, e);
      total_cnt++; if (!p || a !== e) $display("FAIL b2b_pop_%0d act=%h exp=%h popped=%b", i, a, e, p); else pass_cnt++;
      total_cnt++; if (fq.count !== 3'd2) $display("FAIL b2b_count_%0d act=%0d exp=2", i, fq.count); else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, p, a, e);
      total_cnt++; if (!p || a !== e) $display("FAIL b2b_tail_%0d act=%h exp=%h popped=%b", i, a, e, p); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic p; instr_t a, e;
    for (int i = 0; i < 3; i++) step(1'b1, instr_t'(9'h030 + i), 1'b0, 1'b0, p, a, e);
    step(1'b1, 9'h0FF, 1'b1, 1'b1, p, a, e);
    total_cnt++; if (fq.count !== 3'd0) $display("FAIL flush_count act=%0d exp=0", fq.count); else pass_cnt++;
    total_cnt++; if (fq.out_valid !== 1'b0) $display("FAIL flush_out_valid act=%b exp=0", fq.out_valid); else pass_cnt++;
    total_cnt++; if (fq.in_ready !== 1'b1) $display("FAIL flush_in_ready act=%b exp=1", fq.in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, p, a, e);
      total_cnt++; if (fq.out_valid !== 1'b0 || a === 9'h0FF) $display("FAIL flush_leak_%0d act=%h/%b exp=000/0", i, a, fq.out_valid); else pass_cnt++;
    end
    step(1'b0, '0, 1'b0, 1'b1, p, a, e);
    step(1'b1, 9'h055, 1'b0, 1'b0, p, a, e);
    step(1'b0, '0, 1'b1, 1'b0, p, a, e);
    total_cnt++; if (!p || a !== e) $display("FAIL flush_empty_pop act=%h exp=%h popped=%b", a, e, p); else pass_cnt++;
  endtask

`ifdef FETCH_QUEUE_STATS_EN
  task automatic test_stats();
    logic p; instr_t a, e;
    do_reset();
    total_cnt++; if (stall_cycles !== 16'd0) $display("FAIL stall_reset act=%0d exp=0", stall_cycles); else pass_cnt++;
    for (int i = 0; i < 4; i++) step(1'b1, instr_t'(9'h060 + i), 1'b0, 1'b0, p, a, e);
    for (int i = 0; i < 10; i++) step(1'b1, 9'h070, 1'b0, 1'b0, p, a, e);
    total_cnt++; if (stall_cycles !== 16'd10) $display("FAIL stall_count act=%0d exp=10", stall_cycles); else pass_cnt++;
    step(1'b1, 9'h071, 1'b0, 1'b1, p, a, e);
    total_cnt++; if (stall_cycles !== 16'd10) $display("FAIL stall_flush act=%0d exp=10", stall_cycles); else pass_cnt++;
    force dut.stall_q = 16'hFFFE;
    #1;
    release dut.stall_q;
    for (int i = 0; i < 4; i++) step(1'b1, instr_t'(9'h080 + i), 1'b0, 1'b0, p, a, e);
    for (int i = 0; i < 3; i++) step(1'b1, 9'h090, 1'b0, 1'b0, p, a, e);
    total_cnt++; if (stall_cycles !== 16'hFFFF) $display("FAIL stall_sat act=%h exp=ffff", stall_cycles); else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset        = 1'b1;
    fq.in_valid  = 1'b0;
    fq.in_instr  = '0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_flush();
`ifdef FETCH_QUEUE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
